// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: LC-3 memory access controller.
// Runs each memory cycle with WAIT_STATES extra access cycles, returns the
// ready pulse (o_R_Bit) to the microsequencer, and, when LC3_MEM_DMA_EN is
// defined, shares the memory port with a DMA requester using round-robin
// arbitration.
// Ports:
//   i_CLK, i_Reset_n                 clock, async active-low reset
//   i_MIO_EN, i_R_W, i_MAR, i_MDR    CPU request, direction, address, data
//   o_R_Bit, o_MDR_Load              CPU ready pulse, captured read data
//   i_DMA_Req/WE/Addr/WData          DMA request (used only with LC3_MEM_DMA_EN)
//   o_DMA_Gnt, o_DMA_Done            DMA owns port / DMA completion pulse
//   o_Mem_CE/WE/Addr/WData           synchronous memory port
//   i_Mem_RData                      memory read data
// All outputs are registered, so no request input reaches the memory
// outputs combinationally.
module lc3_mem_arbiter #(
  parameter int unsigned WAIT_STATES = 3
) (
  input  logic        i_CLK,
  input  logic        i_Reset_n,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  input  logic [15:0] i_MAR,
  input  logic [15:0] i_MDR,
  output logic        o_R_Bit,
  output logic [15:0] o_MDR_Load,
  input  logic        i_DMA_Req,
  input  logic        i_DMA_WE,
  input  logic [15:0] i_DMA_Addr,
  input  logic [15:0] i_DMA_WData,
  output logic        o_DMA_Gnt,
  output logic        o_DMA_Done,
  output logic        o_Mem_CE,
  output logic        o_Mem_WE,
  output logic [15:0] o_Mem_Addr,
  output logic [15:0] o_Mem_WData,
  input  logic [15:0] i_Mem_RData
);

  localparam int unsigned CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       mdr_q, mdr_d;
  logic              ce_q, ce_d;
  logic              mem_we_q, mem_we_d;
  logic              r_bit_q, r_bit_d;
  logic              grant_cpu_c;

`ifdef LC3_MEM_DMA_EN
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;
  logic   gnt_q, gnt_d;
  logic   done_q, done_d;
  logic   grant_dma_c;

  // Round-robin: on a tie the requester that did not go last wins.
  always_comb begin
    grant_cpu_c = 1'b0;
    grant_dma_c = 1'b0;
    if (i_MIO_EN && !(i_DMA_Req && last_q == OWN_CPU)) begin
      grant_cpu_c = 1'b1;
    end else if (i_DMA_Req) begin
      grant_dma_c = 1'b1;
    end
  end
`else
  logic unused_dma_c;
  assign unused_dma_c = ^{i_DMA_Req, i_DMA_WE, i_DMA_Addr, i_DMA_WData};
  assign grant_cpu_c  = i_MIO_EN;
`endif

  // Next-state, latch and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdr_d   = mdr_q;
`ifdef LC3_MEM_DMA_EN
    owner_d = owner_q;
    last_d  = last_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant_cpu_c) begin
          addr_d  = i_MAR;
          wdata_d = i_MDR;
          dir_d   = i_R_W;
          cnt_d   = '0;
          state_d = ST_ACCESS;
`ifdef LC3_MEM_DMA_EN
          owner_d = OWN_CPU;
          last_d  = OWN_CPU;
        end else if (grant_dma_c) begin
          addr_d  = i_DMA_Addr;
          wdata_d = i_DMA_WData;
          dir_d   = i_DMA_WE;
          cnt_d   = '0;
          state_d = ST_ACCESS;
          owner_d = OWN_DMA;
          last_d  = OWN_DMA;
`endif
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          // Read data is valid on the final access cycle.
          if (!dir_q) mdr_d = i_Mem_RData;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    ce_d     = (state_d == ST_ACCESS);
    mem_we_d = ce_d && dir_d && (cnt_d == CNT_LAST);
`ifdef LC3_MEM_DMA_EN
    r_bit_d  = (state_d == ST_DONE) && (owner_d == OWN_CPU);
    gnt_d    = (state_d != ST_IDLE) && (owner_d == OWN_DMA);
    done_d   = (state_d == ST_DONE) && (owner_d == OWN_DMA);
`else
    r_bit_d  = (state_d == ST_DONE);
`endif
  end

  // State and output registers; reset aborts any access at once.
  always_ff @(posedge i_CLK or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mdr_q    <= '0;
      ce_q     <= 1'b0;
      mem_we_q <= 1'b0;
      r_bit_q  <= 1'b0;
`ifdef LC3_MEM_DMA_EN
      owner_q  <= OWN_CPU;
      last_q   <= OWN_DMA;
      gnt_q    <= 1'b0;
      done_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mdr_q    <= mdr_d;
      ce_q     <= ce_d;
      mem_we_q <= mem_we_d;
      r_bit_q  <= r_bit_d;
`ifdef LC3_MEM_DMA_EN
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
`endif
    end
  end

  assign o_R_Bit     = r_bit_q;
  assign o_MDR_Load  = mdr_q;
  assign o_Mem_CE    = ce_q;
  assign o_Mem_WE    = mem_we_q;
  assign o_Mem_Addr  = addr_q;
  assign o_Mem_WData = wdata_q;
`ifdef LC3_MEM_DMA_EN
  assign o_DMA_Gnt   = gnt_q;
  assign o_DMA_Done  = done_q;
`else
  assign o_DMA_Gnt   = 1'b0;
  assign o_DMA_Done  = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: CPU transaction table on a
// WAIT_STATES=3 instance, reset abort, back-to-back on a WAIT_STATES=0
// instance, and DMA round-robin (or DMA-ignored behaviour) per build.
module tb_lc3_mem_arbiter;

  localparam int unsigned WS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst0_n = 1'b1;
  logic        mio = 1'b0, rw = 1'b0;
  logic [15:0] mar = '0, mdr = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0;
  logic        r_bit, dma_gnt, dma_done, mem_ce, mem_we;
  logic [15:0] mdr_load, mem_addr, mem_wdata, mem_rdata;

  logic        mio0 = 1'b0;
  logic        r_bit0, dma_gnt0, dma_done0, mem_ce0, mem_we0;
  logic [15:0] mdr_load0, mem_addr0, mem_wdata0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.WAIT_STATES(WS)) dut (
    .i_CLK(clk), .i_Reset_n(rst_n),
    .i_MIO_EN(mio), .i_R_W(rw), .i_MAR(mar), .i_MDR(mdr),
    .o_R_Bit(r_bit), .o_MDR_Load(mdr_load),
    .i_DMA_Req(dma_req), .i_DMA_WE(dma_we), .i_DMA_Addr(dma_addr), .i_DMA_WData(dma_wdata),
    .o_DMA_Gnt(dma_gnt), .o_DMA_Done(dma_done),
    .o_Mem_CE(mem_ce), .o_Mem_WE(mem_we), .o_Mem_Addr(mem_addr), .o_Mem_WData(mem_wdata),
    .i_Mem_RData(mem_rdata)
  );

  lc3_mem_arbiter #(.WAIT_STATES(0)) dut0 (
    .i_CLK(clk), .i_Reset_n(rst0_n),
    .i_MIO_EN(mio0), .i_R_W(1'b0), .i_MAR(16'h0100), .i_MDR(16'h0000),
    .o_R_Bit(r_bit0), .o_MDR_Load(mdr_load0),
    .i_DMA_Req(1'b0), .i_DMA_WE(1'b0), .i_DMA_Addr(16'h0000), .i_DMA_WData(16'h0000),
    .o_DMA_Gnt(dma_gnt0), .o_DMA_Done(dma_done0),
    .o_Mem_CE(mem_ce0), .o_Mem_WE(mem_we0), .o_Mem_Addr(mem_addr0), .o_Mem_WData(mem_wdata0),
    .i_Mem_RData(16'hC0DE)
  );

  // Synchronous memory model: data registered while CE is high.
  logic [15:0] mem [256];
  function automatic logic [7:0] midx(input logic [15:0] a);
    return {a[15:12], a[3:0]};
  endfunction
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) mem[midx(mem_addr)] <= mem_wdata;
      mem_rdata <= mem[midx(mem_addr)];
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_mdr;
  } vec_t;

  // One CPU access starting in an IDLE cycle; checks every cycle to R.
  task automatic cpu_access(input vec_t v);
    @(negedge clk);
    mio = 1'b1; rw = v.rw; mar = v.addr; mdr = v.wdata;
    for (int k = 1; k <= int'(WS) + 2; k++) begin
      @(negedge clk);
      chk($sformatf("ce k=%0d", k), 16'(mem_ce), 16'(k <= int'(WS) + 1));
      chk($sformatf("we k=%0d", k), 16'(mem_we), 16'(v.rw && k == int'(WS) + 1));
      chk($sformatf("r k=%0d", k), 16'(r_bit), 16'(k == int'(WS) + 2));
      chk($sformatf("gnt k=%0d", k), 16'({dma_gnt, dma_done}), 16'h0);
      if (k == 1) begin
        // Requester inputs may change once granted.
        mar = 16'hDEAD; mdr = 16'hDEAD; rw = ~v.rw;
      end
      if (k == int'(WS) + 1) begin
        chk("addr latched", mem_addr, v.addr);
        if (v.rw) chk("wdata latched", mem_wdata, v.wdata);
      end
      if (k == int'(WS) + 2) begin
        chk("mdr_load", mdr_load, v.exp_mdr);
        mio = 1'b0;
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[midx(16'h3000)] = 16'hBEEF;
    mem[midx(16'h0000)] = 16'h5A5A;
    mem[midx(16'h5000)] = 16'hAAAA;

    vecs[0] = '{rw: 1'b0, addr: 16'h3000, wdata: 16'h0000, exp_mdr: 16'hBEEF};
    vecs[1] = '{rw: 1'b1, addr: 16'h4000, wdata: 16'h1234, exp_mdr: 16'hBEEF};
    vecs[2] = '{rw: 1'b0, addr: 16'h4000, wdata: 16'hFFFF, exp_mdr: 16'h1234};
    vecs[3] = '{rw: 1'b1, addr: 16'h3000, wdata: 16'h0F0F, exp_mdr: 16'h1234};
    vecs[4] = '{rw: 1'b0, addr: 16'h3000, wdata: 16'h0000, exp_mdr: 16'h0F0F};
    vecs[5] = '{rw: 1'b0, addr: 16'h0000, wdata: 16'h0000, exp_mdr: 16'h5A5A};

    #1 rst_n = 1'b0; rst0_n = 1'b0;
    #2;
    chk("rst r_bit", 16'(r_bit), 16'h0);
    chk("rst mdr_load", mdr_load, 16'h0);
    chk("rst dma_gnt", 16'(dma_gnt), 16'h0);
    chk("rst dma_done", 16'(dma_done), 16'h0);
    chk("rst ce", 16'(mem_ce), 16'h0);
    chk("rst we", 16'(mem_we), 16'h0);
    chk("rst addr", mem_addr, 16'h0);
    chk("rst wdata", mem_wdata, 16'h0);
    @(negedge clk); rst_n = 1'b1; rst0_n = 1'b1;

`ifdef LC3_MEM_DMA_EN
    dma_req = 1'b0;
`else
    // DMA must be ignored entirely in this build.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h6001; dma_wdata = 16'h9999;
`endif
    for (int i = 0; i < 6; i++) cpu_access(vecs[i]);
    dma_req = 1'b0;

    // Reset in cycle 3 of a write: CE/WE drop without a clock edge.
    @(negedge clk);
    mio = 1'b1; rw = 1'b1; mar = 16'h5000; mdr = 16'h7777;
    repeat (3) @(negedge clk);
    chk("abort ce before", 16'(mem_ce), 16'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort ce async", 16'(mem_ce), 16'h0);
    chk("abort we async", 16'(mem_we), 16'h0);
    mio = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort r in reset", 16'(r_bit), 16'h0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort no r", 16'(r_bit), 16'h0);
      chk("abort no ce", 16'(mem_ce), 16'h0);
    end
    cpu_access('{rw: 1'b0, addr: 16'h5000, wdata: 16'h0000, exp_mdr: 16'hAAAA});

    // WAIT_STATES=0, request held: R in cycles 2, 5, 8.
    @(negedge clk);
    mio0 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("ws0 r k=%0d", k), 16'(r_bit0), 16'(k % 3 == 2));
      chk($sformatf("ws0 ce k=%0d", k), 16'(mem_ce0), 16'(k % 3 == 1));
    end
    mio0 = 1'b0;
    chk("ws0 mdr_load", mdr_load0, 16'hC0DE);

`ifdef LC3_MEM_DMA_EN
    // Both request from reset and hold: CPU, DMA, CPU.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    mio = 1'b1; rw = 1'b0; mar = 16'h3000;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h6001; dma_wdata = 16'h9999;
    for (int k = 1; k <= 3 * (int'(WS) + 3) - 1; k++) begin
      int  p, ph;
      logic is_dma;
      p = int'(WS) + 3;
      ph = k % p;
      is_dma = ((k / p) % 2) == 1;
      @(negedge clk);
      chk($sformatf("rr ce k=%0d", k), 16'(mem_ce), 16'(ph >= 1 && ph <= int'(WS) + 1));
      chk($sformatf("rr gnt k=%0d", k), 16'(dma_gnt), 16'(is_dma && ph >= 1));
      chk($sformatf("rr done k=%0d", k), 16'(dma_done), 16'(is_dma && ph == int'(WS) + 2));
      chk($sformatf("rr r k=%0d", k), 16'(r_bit), 16'(!is_dma && ph == int'(WS) + 2));
      chk($sformatf("rr we k=%0d", k), 16'(mem_we), 16'(is_dma && ph == int'(WS) + 1));
      if (is_dma && ph == int'(WS) + 1) begin
        chk("rr dma addr", mem_addr, 16'h6001);
        chk("rr dma wdata", mem_wdata, 16'h9999);
      end
      if (!is_dma && ph == int'(WS) + 2) chk("rr cpu mdr", mdr_load, 16'h0F0F);
    end
    mio = 1'b0; dma_req = 1'b0;
    cpu_access('{rw: 1'b0, addr: 16'h6001, wdata: 16'h0000, exp_mdr: 16'h9999});
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Memory access controller for the LC-3 core. It sequences every memory cycle with a fixed number of wait states and generates the ready bit (R) that the microsequencer polls in its COND=R states. It also shares the single synchronous memory port between the CPU (MAR/MDR path) and an optional DMA requester, using round-robin arbitration.

## Interface
Parameters:
- WAIT_STATES, 3: extra access cycles beyond the first; legal range 0..15.

Ports:
- i_CLK  in  1  system clock; all state changes on the rising edge.
- i_Reset_n  in  1  reset, asynchronous, active-low.
- i_MIO_EN  in  1  CPU memory request; held high while the microsequencer waits on R.
- i_R_W  in  1  CPU direction; 1 = write, 0 = read.
- i_MAR  in  16  CPU address.
- i_MDR  in  16  CPU write data.
- o_R_Bit  out  1  one-cycle ready pulse to the microsequencer.
- o_MDR_Load  out  16  read data to the MDR input mux; holds the last captured value.
- i_DMA_Req  in  1  DMA request; held until o_DMA_Done.
- i_DMA_WE  in  1  DMA direction; 1 = write.
- i_DMA_Addr  in  16  DMA address.
- i_DMA_WData  in  16  DMA write data.
- o_DMA_Gnt  out  1  high while the DMA owns the port (ACCESS and DONE).
- o_DMA_Done  out  1  one-cycle completion pulse to the DMA.
- o_Mem_CE  out  1  memory chip enable.
- o_Mem_WE  out  1  memory write strobe.
- o_Mem_Addr  out  16  memory address.
- o_Mem_WData  out  16  memory write data.
- i_Mem_RData  in  16  memory read data; synchronous memory, valid while CE is high.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Owner register r_Owner: CPU or DMA.
- Last-grant register r_Last: resets to DMA, so the CPU wins the first tie.
- IDLE:
  - Sample i_MIO_EN and i_DMA_Req.
  - One requester only: grant it.
  - Both requesting: grant the requester that is not r_Last.
  - On grant: latch address, write data and direction into registers; clear the wait counter; set r_Owner and r_Last; go to ACCESS.
- ACCESS:
  - o_Mem_CE = 1.
  - o_Mem_Addr and o_Mem_WData come from the latched registers, so requester inputs may change after the grant.
  - The counter increments each cycle.
  - On the cycle where counter == WAIT_STATES:
    - Writes: o_Mem_WE = 1 for this cycle only.
    - Reads: i_Mem_RData is captured at this edge into o_MDR_Load (CPU owner) or o_DMA_RData-equivalent o_MDR_Load path (DMA owner uses the same register).
    - Go to DONE.
- DONE:
  - Pulse o_R_Bit (CPU owner) or o_DMA_Done (DMA owner) for exactly one cycle.
  - Next state is IDLE.
- A request still high in the IDLE cycle after DONE is a new access: the microsequencer has already consumed R. No request ID or edge detection is used.
- Counter width: max(1, clog2(WAIT_STATES+1)). The counter never wraps because it exits at WAIT_STATES.

## Timing
- Reset values: FSM = IDLE; r_Owner = CPU; r_Last = DMA.
  - Zero: o_R_Bit, o_DMA_Gnt, o_DMA_Done, o_Mem_CE, o_Mem_WE, o_Mem_Addr, o_Mem_WData, o_MDR_Load.
- Reset mid-access: aborts the access immediately (asynchronously). CE and WE drop without waiting for a clock, and no R or Done pulse follows.
- Latency: request high in IDLE cycle 0; ACCESS in cycles 1..WAIT_STATES+1; R/Done in cycle WAIT_STATES+2.
  - Default WAIT_STATES=3: R in cycle 5.
- Back-to-back throughput: one access per WAIT_STATES+3 cycles.
- Simultaneous requests: strict alternation while both stay high.
- A request dropped during ACCESS does not abort the access; the pulse is still issued.
- Outputs are registered or decoded from FSM state only. No combinational path from request inputs to memory outputs.

## Configuration
- LC3_MEM_DMA_EN defined: DMA port and round-robin arbitration are active as described.
- LC3_MEM_DMA_EN undefined:
  - DMA inputs are ignored; o_DMA_Gnt and o_DMA_Done are tied to 0.
  - r_Owner and r_Last are removed; the CPU is always granted.
  - CPU latency and timing are unchanged.

## Test plan
- CPU read, WAIT_STATES=3, memory at 0x3000 = 0xBEEF; MIO_EN=1, R_W=0 at cycle 0 -> CE high cycles 1-4, o_R_Bit high only in cycle 5, o_MDR_Load = 0xBEEF from cycle 5.
- CPU write 0x1234 to 0x4000 -> o_Mem_WE high only in cycle 4 with Addr=0x4000 and WData=0x1234; R in cycle 5; memory readback = 0x1234.
- CPU and DMA both request from reset and hold requests -> grant order CPU, DMA, CPU; o_DMA_Gnt high during DMA ACCESS+DONE; o_DMA_Done single-cycle pulse.
- i_Reset_n pulled low in cycle 3 of a write -> CE and WE drop immediately, no R pulse, FSM in IDLE; next request after reset completes normally.
- WAIT_STATES=0, MIO_EN held high continuously -> R pulses every 3 cycles (cycles 2, 5, 8).
- LC3_MEM_DMA_EN undefined, i_DMA_Req=1 constantly -> o_DMA_Gnt = o_DMA_Done = 0 always; CPU read latency still WAIT_STATES+2.
